// File: rtl/lite16_ctrl_if.sv
// Control-unit boundary of the LITE-16 core: instruction/compare/memory-ready inputs
// plus the decode, strobe, PC-update and status outputs.
interface lite16_ctrl_if;
    logic [15:0] imem_data;
    logic        cmp;
    logic        dmem_ready;
    logic [15:0] ir;
    logic [2:0]  codeop;
    logic        ri;
    logic        ld;
    logic        jmp;
    logic        rf_we;
    logic        dmem_re;
    logic        dmem_we;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    modport master (
        input  imem_data, cmp, dmem_ready,
        output ir, codeop, ri, ld, jmp, rf_we, dmem_re, dmem_we,
               pc_write, pc_src, halted, fault, retired
    );

    modport slave (
        output imem_data, cmp, dmem_ready,
        input  ir, codeop, ri, ld, jmp, rf_we, dmem_re, dmem_we,
               pc_write, pc_src, halted, fault, retired
    );
endinterface

// File: rtl/lite16_ctrl.sv
// LITE-16 multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with retire count.
// Latency: R/I 4, branch 3, load 5+N, store 4+N, jump 4; stalls in MEM until dmem_ready or timeout.
// Backpressure: dmem_ready only; a missing ready for MEM_TIMEOUT MEM cycles halts with fault.
module lite16_ctrl #(
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    lite16_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] ir_q;
    logic [15:0] retired_q;
    logic [15:0] tmo_cnt;
    logic        fault_q;

    logic is_halt, op_r, op_i, op_ld, op_st, op_br, op_jal;
    logic active, retire;

    always_comb begin
        is_halt = (ir_q == HALT_WORD);
        op_r    = !is_halt && (ir_q[15:14] == 2'b00);
        op_i    = !is_halt && (ir_q[15:14] == 2'b01);
        op_ld   = !is_halt && (ir_q[15:14] == 2'b10) && !ir_q[13];
        op_st   = !is_halt && (ir_q[15:14] == 2'b10) &&  ir_q[13];
        op_br   = !is_halt && (ir_q[15:14] == 2'b11) && !ir_q[13];
        op_jal  = !is_halt && (ir_q[15:14] == 2'b11) &&  ir_q[13];
        active  = (state == S_DECODE) || (state == S_EXEC) ||
                  (state == S_MEM)    || (state == S_WB);
    end

    // ALU controls depend only on ir, which is frozen from DECODE through WB.
    always_comb begin
        bus.codeop = 3'b000;
        bus.ri     = 1'b0;
        bus.ld     = 1'b0;
        bus.jmp    = 1'b0;
        if (active) begin
            if (op_r || op_i) bus.codeop = ir_q[13:11];
            else if (op_br)   bus.codeop = {1'b0, ir_q[12:11]};
            bus.ri  = op_i;
            bus.ld  = op_ld;
            bus.jmp = op_jal;
        end
    end

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.dmem_re  = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_src   = 2'b00;
        retire       = 1'b0;
        if (!rst) begin
            unique case (state)
                S_EXEC: begin
                    if (op_br) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = bus.cmp ? 2'b01 : 2'b00;
                        retire       = 1'b1;
                    end
                end
                S_MEM: begin
                    bus.dmem_re = op_ld;
                    bus.dmem_we = op_st;
                    // The store completes on its final write beat, so the PC advances alongside it.
                    if (op_st && bus.dmem_ready) begin
                        bus.pc_write = 1'b1;
                        retire       = 1'b1;
                    end
                end
                S_WB: begin
                    bus.rf_we    = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = op_jal ? 2'b10 : 2'b00;
                    retire       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ir_q      <= 16'h0000;
            retired_q <= 16'h0000;
            tmo_cnt   <= 16'h0000;
            fault_q   <= 1'b0;
        end else begin
            if (retire) retired_q <= retired_q + 16'd1;
            unique case (state)
                S_FETCH: begin
                    ir_q  <= bus.imem_data;
                    state <= S_DECODE;
                end
                S_DECODE: state <= is_halt ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (op_br) begin
                        state <= S_FETCH;
                    end else if (op_ld || op_st) begin
                        state   <= S_MEM;
                        tmo_cnt <= 16'h0000;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        state <= op_ld ? S_WB : S_FETCH;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        state   <= S_HALT;
                        fault_q <= 1'b1;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.ir      = ir_q;
    assign bus.retired = retired_q;
    assign bus.fault   = fault_q;
    assign bus.halted  = (state == S_HALT);

endmodule

// File: tb/tb_lite16_ctrl.sv
// Directed bench for lite16_ctrl: walks each instruction class cycle by cycle
// against hand-computed strobe patterns (strb = {rf_we, dmem_re, dmem_we, pc_write}).
module tb_lite16_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    lite16_ctrl_if bus ();

    lite16_ctrl #(.MEM_TIMEOUT(4), .HALT_WORD(16'hFFFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] strb;
    assign strb = {bus.rf_we, bus.dmem_re, bus.dmem_we, bus.pc_write};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Enters in FETCH, leaves in the following FETCH.
    task automatic run_rtype(input logic [15:0] expect_retired);
        bus.imem_data = 16'h0123;
        tick();
        tick();
        tick();
        check("rt_wb_strb", strb, 4'b1001);
        tick();
        check("rt_retired", bus.retired, expect_retired);
    endtask

    initial begin
        rst            = 1'b1;
        bus.imem_data  = 16'h0000;
        bus.cmp        = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();
        check("rst_ir", bus.ir, 16'h0000);
        check("rst_retired", bus.retired, 16'h0000);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_fault", bus.fault, 1'b0);
        check("rst_strb", strb, 4'b0000);

        // R-type: cycle 4 is WB
        bus.imem_data = 16'h0123;
        tick();
        check("r_ir", bus.ir, 16'h0123);
        check("r_codeop", bus.codeop, 3'b000);
        check("r_ri", bus.ri, 1'b0);
        tick();
        check("r_exec_strb", strb, 4'b0000);
        tick();
        check("r_wb_strb", strb, 4'b1001);
        check("r_wb_pcsrc", bus.pc_src, 2'b00);
        tick();
        check("r_retired", bus.retired, 16'd1);

        // I-type 16'h5800: codeop = 011, ri = 1
        bus.imem_data = 16'h5800;
        tick();
        check("i_codeop", bus.codeop, 3'b011);
        check("i_ri", bus.ri, 1'b1);
        tick();
        tick();
        check("i_wb_strb", strb, 4'b1001);
        check("i_wb_ldjmp", {bus.ld, bus.jmp}, 2'b00);
        tick();
        check("i_retired", bus.retired, 16'd2);

        // Branch taken: retires in EXEC (cycle 3)
        bus.imem_data = 16'hC800;
        bus.cmp       = 1'b1;
        tick();
        check("br_codeop", bus.codeop, 3'b001);
        tick();
        check("br_t_strb", strb, 4'b0001);
        check("br_t_pcsrc", bus.pc_src, 2'b01);
        tick();
        check("br_t_retired", bus.retired, 16'd3);

        // Branch not taken
        bus.cmp = 1'b0;
        tick();
        tick();
        check("br_n_strb", strb, 4'b0001);
        check("br_n_pcsrc", bus.pc_src, 2'b00);
        tick();
        check("br_n_retired", bus.retired, 16'd4);

        // Load with 3 wait cycles; ready arrives as the counter reaches its limit
        bus.imem_data = 16'h8000;
        tick();
        check("ld_dec_ld", bus.ld, 1'b1);
        tick();
        check("ld_exec_strb", strb, 4'b0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.dmem_ready = (i == 3);
            #1;
            check("ld_mem_strb", strb, 4'b0100);
            tick();
        end
        bus.dmem_ready = 1'b0;
        #1;
        check("ld_wb_strb", strb, 4'b1001);
        check("ld_wb_ld", bus.ld, 1'b1);
        check("ld_wb_pcsrc", bus.pc_src, 2'b00);
        tick();
        check("ld_retired", bus.retired, 16'd5);

        // Store, ready immediately
        bus.imem_data = 16'hA000;
        tick();
        tick();
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        check("st_mem_strb", strb, 4'b0011);
        check("st_mem_pcsrc", bus.pc_src, 2'b00);
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        check("st_retired", bus.retired, 16'd6);
        check("st_fetch_strb", strb, 4'b0000);

        // Jump-and-link
        bus.imem_data = 16'hE000;
        tick();
        check("jal_dec_jmp", bus.jmp, 1'b1);
        tick();
        check("jal_exec_strb", strb, 4'b0000);
        tick();
        check("jal_wb_strb", strb, 4'b1001);
        check("jal_wb_pcsrc", bus.pc_src, 2'b10);
        check("jal_wb_jmp", bus.jmp, 1'b1);
        tick();
        check("jal_retired", bus.retired, 16'd7);

        // Halt word
        bus.imem_data = 16'hFFFF;
        tick();
        check("hlt_dec_halted", bus.halted, 1'b0);
        tick();
        check("hlt_halted", bus.halted, 1'b1);
        check("hlt_strb", strb, 4'b0000);
        tick();
        tick();
        check("hlt_sticky", bus.halted, 1'b1);
        check("hlt_retired", bus.retired, 16'd7);
        check("hlt_fault", bus.fault, 1'b0);

        do_reset();
        check("rst2_halted", bus.halted, 1'b0);
        check("rst2_retired", bus.retired, 16'd0);

        // Store timeout with MEM_TIMEOUT = 4
        run_rtype(16'd1);
        bus.imem_data  = 16'hA000;
        bus.dmem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tmo_mem_strb", strb, 4'b0010);
        end
        tick();
        check("tmo_halted", bus.halted, 1'b1);
        check("tmo_fault", bus.fault, 1'b1);
        check("tmo_retired", bus.retired, 16'd1);
        check("tmo_strb", strb, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("tmo_rst_status", {bus.halted, bus.fault}, 2'b00);
        check("tmo_rst_retired", bus.retired, 16'd0);
        check("tmo_rst_ir", bus.ir, 16'h0000);

        // Reset during a load wait
        run_rtype(16'd1);
        bus.imem_data = 16'h8000;
        tick();
        tick();
        tick();
        check("ldrst_mem1_re", bus.dmem_re, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check("ldrst_rstcyc_strb", strb, 4'b0000);
        tick();
        rst = 1'b0;
        #1;
        check("ldrst_strb", strb, 4'b0000);
        check("ldrst_retired", bus.retired, 16'd0);
        run_rtype(16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
